// File: rtl/lut_arb_pkg.sv
// Shared types and default sizing for the LUT port arbiter: FSM state
// encoding and the parameter defaults used by the top level.
package lut_arb_pkg;

  localparam int DEF_NREQ           = 4;
  localparam int DEF_ABITS          = 4;
  localparam int DEF_DBITS          = 2;
  localparam bit DEF_CLEAR_ON_RESET = 1'b1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first eligible requester at or after the
// pointer, wrapping modulo N, as a one-hot grant plus a valid flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_valid
);

  logic [PW-1:0] w_idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (!o_valid && i_elig[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_port_arbiter.sv
// Multi-requester arbiter in front of a single-port RW lookup table, with an
// optional zero-fill pass after reset or on demand.
module lut_port_arbiter
  import lut_arb_pkg::*;
#(
  parameter int NREQ           = DEF_NREQ,
  parameter int ABITS          = DEF_ABITS,
  parameter int DBITS          = DEF_DBITS,
  parameter bit CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ABITS-1:0]  req_addr,
  input  logic [NREQ*DBITS-1:0]  req_wdata,
  output logic [NREQ-1:0]        ack,
  output logic [DBITS-1:0]       rdata,
  output logic                   busy,
  output logic [ABITS-1:0]       mem_addr,
  output logic                   mem_wr_en,
  output logic [DBITS-1:0]       mem_wr_data,
  input  logic [DBITS-1:0]       mem_rd_data
);

  localparam int               PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ABITS-1:0] LAST_ADDR = '1;
  localparam state_e           RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_e           r_state;
  logic [ABITS-1:0] r_cnt;
  logic [PW-1:0]    r_ptr;
  logic [NREQ-1:0]  r_ack;
  logic [DBITS-1:0] r_rdata;

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_grant;
  logic             w_grant_vld;
  logic [PW-1:0]    w_win_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic [ABITS-1:0] w_sel_addr;
  logic             w_sel_we;
  logic [DBITS-1:0] w_sel_wdata;

  // A requester whose ack is going out this cycle is masked so it cannot be
  // served twice back to back; clr and rst suppress any new grant.
  assign w_elig = (r_state == RUN && !rst && !clr) ? (req & ~r_ack) : '0;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_grant_vld)
  );

  always_comb begin
    w_win_idx   = '0;
    w_sel_addr  = '0;
    w_sel_we    = 1'b0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_win_idx   = PW'(i);
        w_sel_addr  = req_addr[i*ABITS +: ABITS];
        w_sel_we    = req_we[i];
        w_sel_wdata = req_wdata[i*DBITS +: DBITS];
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    if (!rst) begin
      if (r_state == CLEAR) begin
        mem_addr  = r_cnt;
        mem_wr_en = 1'b1;
      end else if (w_grant_vld) begin
        mem_addr    = w_sel_addr;
        mem_wr_en   = w_sel_we;
        mem_wr_data = w_sel_wdata;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_grant;
      if (w_grant_vld) begin
        r_rdata <= mem_rd_data;
        r_ptr   <= w_ptr_nxt;
      end
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) r_state <= RUN;
        end
        RUN: begin
          if (clr) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign ack   = r_ack;
  assign rdata = r_rdata;
  assign busy  = (r_state == CLEAR);

endmodule
